scan_link_arbiter: RTL and testbench

//  Shares the single upload/transfer channel between two scanner units.

---
 rtl/scan_link_arbiter.sv | 138 +++++++++++++
 tb/tb_scan_link_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/scan_link_arbiter.sv
// rtl/scan_link_arbiter.sv - round-robin channel arbiter for two scanners with hold limit, turnaround gap and command relay
// Optional tenure statistics counters: define SCAN_ARB_STATS_EN.
module scan_link_arbiter #(
    parameter int HOLD_CYCLES = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] done,
    input  logic [1:0] comm0_in,
    input  logic [1:0] comm1_in,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout,
    output logic [1:0] comm0_out,
    output logic [1:0] comm1_out,
    output logic [7:0] grant_cnt0,
    output logic [7:0] grant_cnt1
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             last_q, last_d;
    logic [1:0]       grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       comm0_out_q, comm0_out_d;
    logic [1:0]       comm1_out_q, comm1_out_d;

    logic             pick1;
    logic             served;
    logic             at_limit;

    // The scanner not served last is preferred; a lone requester always wins.
    assign pick1    = last_q ? ~req[0] : req[1];
    assign served   = (state_q == S_GRANT1);
    assign at_limit = (hold_q == LIMIT);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        last_d      = last_q;
        timeout_d   = 1'b0;
        comm0_out_d = comm1_in;
        comm1_out_d = comm0_in;
        case (state_q)
            S_IDLE, S_GAP: begin
                if (|req) begin
                    state_d = pick1 ? S_GRANT1 : S_GRANT0;
                    hold_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (done[served] || !req[served] || at_limit) begin
                    state_d   = S_GAP;
                    last_d    = served;
                    timeout_d = at_limit && !done[served];
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        grant_d = {state_d == S_GRANT1, state_d == S_GRANT0};
        busy_d  = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            last_q      <= 1'b1;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            comm0_out_q <= 2'b00;
            comm1_out_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            comm0_out_q <= comm0_out_d;
            comm1_out_q <= comm1_out_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;
    assign comm0_out = comm0_out_q;
    assign comm1_out = comm1_out_q;

`ifdef SCAN_ARB_STATS_EN
    logic [7:0] grant_cnt0_q, grant_cnt0_d;
    logic [7:0] grant_cnt1_q, grant_cnt1_d;

    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (state_d == S_GRANT0 && state_q != S_GRANT0 && grant_cnt0_q != 8'hFF)
            grant_cnt0_d = grant_cnt0_q + 8'd1;
        if (state_d == S_GRANT1 && state_q != S_GRANT1 && grant_cnt1_q != 8'hFF)
            grant_cnt1_d = grant_cnt1_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0_q <= 8'h00;
            grant_cnt1_q <= 8'h00;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`else
    assign grant_cnt0 = 8'h00;
    assign grant_cnt1 = 8'h00;
`endif

endmodule

// File: tb/tb_scan_link_arbiter.sv
// tb/tb_scan_link_arbiter.sv - directed scoreboard bench for scan_link_arbiter
module tb_scan_link_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req, done, comm0_in, comm1_in;
    logic [1:0] grant, comm0_out, comm1_out;
    logic       busy, timeout;
    logic [7:0] grant_cnt0, grant_cnt1;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] g;
        logic       t;
        logic [1:0] c0;
        logic [1:0] c1;
    } exp_t;

    exp_t sb[$];

    scan_link_arbiter #(.HOLD_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .comm0_in(comm0_in), .comm1_in(comm1_in),
        .grant(grant), .busy(busy), .timeout(timeout),
        .comm0_out(comm0_out), .comm1_out(comm1_out),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, queue the outputs the next edge must produce, then compare.
    task automatic cyc(input logic rst, input logic [1:0] r, input logic [1:0] d,
                       input logic [1:0] eg, input logic et);
        exp_t e;
        reset = rst;
        req   = r;
        done  = d;
        e.g   = rst ? 2'b00 : eg;
        e.t   = rst ? 1'b0 : et;
        e.c0  = rst ? 2'b00 : comm1_in;
        e.c1  = rst ? 2'b00 : comm0_in;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("grant", {6'd0, grant}, {6'd0, e.g});
        chk("busy", {7'd0, busy}, {7'd0, |e.g});
        chk("timeout", {7'd0, timeout}, {7'd0, e.t});
        chk("comm0_out", {6'd0, comm0_out}, {6'd0, e.c0});
        chk("comm1_out", {6'd0, comm1_out}, {6'd0, e.c1});
    endtask

    // A full-length tenure followed by its timeout gap.
    task automatic full_tenure(input logic [1:0] r, input logic [1:0] g);
        for (int i = 0; i < 10; i++) cyc(1'b0, r, 2'b00, g, 1'b0);
        cyc(1'b0, r, 2'b00, 2'b00, 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        req      = 2'b00;
        done     = 2'b00;
        comm0_in = 2'b00;
        comm1_in = 2'b00;

        // reset state
        cyc(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        cyc(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        chk("cnt0_reset", grant_cnt0, 8'h00);
        chk("cnt1_reset", grant_cnt1, 8'h00);

        // both request from reset: scanner 0 first, then alternate with timeouts
        full_tenure(2'b11, 2'b01);
        full_tenure(2'b11, 2'b10);
        cyc(1'b0, 2'b11, 2'b00, 2'b01, 1'b0);
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);   // req drop releases, no timeout
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

        // single requester, early done on 4th grant cycle
        cyc(1'b0, 2'b01, 2'b00, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b01, 2'b00, 2'b01, 1'b0);
        cyc(1'b0, 2'b01, 2'b01, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

        // single requester held: re-grant after one-cycle gap
        full_tenure(2'b01, 2'b01);
        full_tenure(2'b01, 2'b01);
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

        // done coincides with the hold limit: release without timeout
        for (int i = 0; i < 10; i++) cyc(1'b0, 2'b01, 2'b00, 2'b01, 1'b0);
        cyc(1'b0, 2'b01, 2'b01, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

        // both request after scanner 0 was served last: scanner 1 wins
        cyc(1'b0, 2'b11, 2'b00, 2'b10, 1'b0);
        cyc(1'b0, 2'b11, 2'b10, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

        // command relay: one-cycle pulse crosses over, other direction unaffected
        comm0_in = 2'b11;
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        comm0_in = 2'b00;
        comm1_in = 2'b10;
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        comm0_in = 2'b01;
        comm1_in = 2'b00;
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        comm0_in = 2'b00;
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

        // reset during the 5th cycle of a scanner 1 tenure
        for (int i = 0; i < 5; i++) cyc(1'b0, 2'b10, 2'b00, 2'b10, 1'b0);
        comm0_in = 2'b10;
        comm1_in = 2'b01;
        cyc(1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
        comm0_in = 2'b00;
        comm1_in = 2'b00;
        chk("cnt0_midreset", grant_cnt0, 8'h00);
        chk("cnt1_midreset", grant_cnt1, 8'h00);
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

        // 300 short tenures for scanner 0
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 2'b01, 2'b00, 2'b01, 1'b0);
            cyc(1'b0, 2'b01, 2'b01, 2'b00, 1'b0);
        end
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
`ifdef SCAN_ARB_STATS_EN
        chk("cnt0_sat", grant_cnt0, 8'hFF);
`else
        chk("cnt0_sat", grant_cnt0, 8'h00);
`endif
        chk("cnt1_after", grant_cnt1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
